// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by vga_timing_gen towards the pixel stage and pins.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           h_sync;
    logic           v_sync;
    logic           de;
    logic [X_W-1:0] x_pixel;
    logic [Y_W-1:0] y_pixel;
    logic           frame_start;
    logic           pix_tick;
    logic [11:0]    rgb;

    modport master (
        output h_sync,
        output v_sync,
        output de,
        output x_pixel,
        output y_pixel,
        output frame_start,
        output pix_tick,
        output rgb
    );

    modport slave (
        input h_sync,
        input v_sync,
        input de,
        input x_pixel,
        input y_pixel,
        input frame_start,
        input pix_tick,
        input rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with internal pixel-tick divider.
// Optional colour-bar pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    vga_timing_gen_if.master   vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [X_W-1:0] H_FP_AT = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_SY_AT = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] H_BP_AT = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOTAL - 1);

    localparam logic [Y_W-1:0] V_FP_AT = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_SY_AT = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] V_BP_AT = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOTAL - 1);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_TOTAL > (2 ** X_W)) begin : g_bad_xw
        $error("vga_timing_gen: X_W too narrow for H_TOTAL-1");
    end
    if (V_TOTAL > (2 ** Y_W)) begin : g_bad_yw
        $error("vga_timing_gen: Y_W too narrow for V_TOTAL-1");
    end

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    logic [DIV_W-1:0] div_q;
    logic [X_W-1:0]   h_cnt;
    logic [Y_W-1:0]   v_cnt;
    logic             tick;
    logic             h_last;
    logic             v_last;

    phase_e h_phase;
    phase_e v_phase;

    logic           hs_n;
    logic           vs_n;
    logic           de_n;
    logic [X_W-1:0] x_n;
    logic [Y_W-1:0] y_n;
    logic           fs_n;

    logic           hs_q;
    logic           vs_q;
    logic           de_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           fs_q;
    logic           pt_q;

    assign tick   = en && (div_q == DIV_LAST);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_comb begin
        h_phase = PH_BACK;
        unique case (1'b1)
            (h_cnt < H_FP_AT):                       h_phase = PH_ACTIVE;
            (h_cnt >= H_FP_AT && h_cnt < H_SY_AT):   h_phase = PH_FRONT;
            (h_cnt >= H_SY_AT && h_cnt < H_BP_AT):   h_phase = PH_SYNC;
            default:                                 h_phase = PH_BACK;
        endcase
    end

    // Vertical phase depends only on v_cnt, so sync spans whole lines.
    always_comb begin
        v_phase = PH_BACK;
        unique case (1'b1)
            (v_cnt < V_FP_AT):                       v_phase = PH_ACTIVE;
            (v_cnt >= V_FP_AT && v_cnt < V_SY_AT):   v_phase = PH_FRONT;
            (v_cnt >= V_SY_AT && v_cnt < V_BP_AT):   v_phase = PH_SYNC;
            default:                                 v_phase = PH_BACK;
        endcase
    end

    always_comb begin
        hs_n = (h_phase == PH_SYNC) ? HS_ON : ~HS_ON;
        vs_n = (v_phase == PH_SYNC) ? VS_ON : ~VS_ON;
        de_n = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        x_n  = de_n ? h_cnt : '0;
        y_n  = de_n ? v_cnt : '0;
        fs_n = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
            hs_q  <= ~HS_ON;
            vs_q  <= ~VS_ON;
            de_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            fs_q  <= 1'b0;
            pt_q  <= 1'b0;
        end else begin
            pt_q <= tick;
            fs_q <= tick && fs_n;
            if (tick) begin
                div_q <= '0;
                hs_q  <= hs_n;
                vs_q  <= vs_n;
                de_q  <= de_n;
                x_q   <= x_n;
                y_q   <= y_n;
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) begin
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end
            end else if (en) begin
                div_q <= div_q + 1'b1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = X_W + 3;
    localparam logic [BAR_W-1:0] BAR_DEN = BAR_W'(H_ACTIVE);

    logic [BAR_W-1:0] bar_num;
    logic [2:0]       bar;
    logic [11:0]      rgb_n;
    logic [11:0]      rgb_q;

    // Bar index = x*8/H_ACTIVE, computed on the pixel being registered.
    always_comb begin
        bar_num = {x_n, 3'b000};
        bar     = 3'(bar_num / BAR_DEN);
        rgb_n   = 12'h000;
        unique case (bar)
            3'd0: rgb_n = 12'hFFF;
            3'd1: rgb_n = 12'hFF0;
            3'd2: rgb_n = 12'h0FF;
            3'd3: rgb_n = 12'h0F0;
            3'd4: rgb_n = 12'hF0F;
            3'd5: rgb_n = 12'hF00;
            3'd6: rgb_n = 12'h00F;
            3'd7: rgb_n = 12'h000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 12'h000;
        end else if (tick) begin
            rgb_q <= de_n ? rgb_n : 12'h000;
        end
    end

    assign vid.rgb = rgb_q;
`else
    assign vid.rgb = 12'h000;
`endif

    assign vid.h_sync      = hs_q;
    assign vid.v_sync      = vs_q;
    assign vid.de          = de_q;
    assign vid.x_pixel     = x_q;
    assign vid.y_pixel     = y_q;
    assign vid.frame_start = fs_q;
    assign vid.pix_tick    = pt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 15x8 raster, CLK_DIV=2.
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b1;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W(4), .Y_W(3)) vid ();

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .CLK_DIV  (2),
        .HSYNC_POL(0),
        .VSYNC_POL(0),
        .X_W      (4),
        .Y_W      (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .vid  (vid)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        bit    rst;
        bit    en;
        int    cyc;
        bit    hs;
        bit    vs;
        bit    de;
        int    x;
        int    y;
        bit    fs;
        bit    pt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int exp_rgb(input int x, input bit de);
`ifdef VGA_TEST_PATTERN_EN
        if (!de) return 0;
        case (x)
            0: return 'hFFF;
            1: return 'hFF0;
            2: return 'h0FF;
            3: return 'h0F0;
            4: return 'hF0F;
            5: return 'hF00;
            6: return 'h00F;
            default: return 0;
        endcase
`else
        return 0;
`endif
    endfunction

    task automatic check_out(input string tag, input bit hs, input bit vs,
                             input bit de, input int x, input int y,
                             input bit fs, input bit pt);
        chk({tag, ".h_sync"}, int'(vid.h_sync), int'(hs));
        chk({tag, ".v_sync"}, int'(vid.v_sync), int'(vs));
        chk({tag, ".de"}, int'(vid.de), int'(de));
        chk({tag, ".x"}, int'(vid.x_pixel), x);
        chk({tag, ".y"}, int'(vid.y_pixel), y);
        chk({tag, ".frame_start"}, int'(vid.frame_start), int'(fs));
        chk({tag, ".pix_tick"}, int'(vid.pix_tick), int'(pt));
        chk({tag, ".rgb"}, int'(vid.rgb), exp_rgb(x, de));
    endtask

    // e = rising edges since reset release with en held high.
    task automatic check_model(input int e);
        int k, h, v;
        bit t, de, hs, vs;
        if (e < 2) begin
            check_out($sformatf("e%0d", e), 1, 1, 0, 0, 0, 0, 0);
        end else begin
            k  = e / 2 - 1;
            t  = (e % 2) == 0;
            h  = k % 15;
            v  = (k / 15) % 8;
            de = (h < 8) && (v < 4);
            hs = !(h >= 10 && h <= 12);
            vs = !(v >= 5 && v <= 6);
            check_out($sformatf("e%0d", e), hs, vs, de,
                      de ? h : 0, de ? v : 0,
                      t && h == 0 && v == 0, t);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        bit found;

        vecs[0]  = '{"rst_hold",  1, 1, 2,  1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{"edge1",     0, 1, 1,  1, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{"first_px",  0, 1, 1,  1, 1, 1, 0, 0, 1, 1};
        vecs[3]  = '{"no_tick",   0, 1, 1,  1, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{"x1",        0, 1, 1,  1, 1, 1, 1, 0, 0, 1};
        vecs[5]  = '{"x5",        0, 1, 8,  1, 1, 1, 5, 0, 0, 1};
        vecs[6]  = '{"frozen",    0, 0, 20, 1, 1, 1, 5, 0, 0, 0};
        vecs[7]  = '{"resume1",   0, 1, 1,  1, 1, 1, 5, 0, 0, 0};
        vecs[8]  = '{"resume2",   0, 1, 1,  1, 1, 1, 6, 0, 0, 1};
        vecs[9]  = '{"hsync_h10", 0, 1, 8,  0, 1, 0, 0, 0, 0, 1};
        vecs[10] = '{"bp_h13",    0, 1, 6,  1, 1, 0, 0, 0, 0, 1};
        vecs[11] = '{"line1_h0",  0, 1, 4,  1, 1, 1, 0, 1, 0, 1};

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            en    = vecs[i].en;
            step(vecs[i].cyc);
            check_out(vecs[i].name, vecs[i].hs, vecs[i].vs, vecs[i].de,
                      vecs[i].x, vecs[i].y, vecs[i].fs, vecs[i].pt);
        end

        // Two full frames against the raster model.
        reset = 1'b1;
        en    = 1'b1;
        step(2);
        reset = 1'b0;
        for (int e = 1; e <= 480; e++) begin
            step(1);
            check_model(e);
        end

        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1);
            if (vid.pix_tick && vid.de &&
                vid.x_pixel == 4'd6 && vid.y_pixel == 3'd2)
                found = 1'b1;
        end
        chk("find_6_2", int'(found), 1);

        // Reset wins even with en low.
        reset = 1'b1;
        en    = 1'b0;
        step(1);
        check_out("mid_reset", 1, 1, 0, 0, 0, 0, 0);
        step(1);
        check_out("mid_reset2", 1, 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        en    = 1'b1;
        step(1);
        check_model(1);
        step(1);
        check_model(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
